// File: rtl/fir_pkg.sv
// Shared constants for the time-multiplexed FIR engine: default sizes,
// FSM state encodings and the full-precision output width derivation.
package fir_pkg;

  localparam int FIR_TAPS_DEF   = 16;
  localparam int FIR_DWIDTH_DEF = 16;
  localparam int FIR_CWIDTH_DEF = 16;

  localparam logic [1:0] FIR_IDLE = 2'd0;
  localparam logic [1:0] FIR_LOAD = 2'd1;
  localparam logic [1:0] FIR_MAC  = 2'd2;
  localparam logic [1:0] FIR_OUT  = 2'd3;

  // Product width plus enough guard bits to sum TAPS products without overflow.
  function automatic int fir_owidth(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// TAPS x CWIDTH coefficient register file: async reset to zero, gated write
// port with address range check, combinational read on the tap index.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int TAPS   = FIR_TAPS_DEF,
  parameter int CWIDTH = FIR_CWIDTH_DEF,
  parameter int AW     = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [CWIDTH-1:0] i_din,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [CWIDTH-1:0] o_rd_data
);

  logic [CWIDTH-1:0] r_coef [TAPS];
  logic              w_wr_ok;

  // Out-of-range writes are silently dropped; only matters when TAPS is not a power of two.
  assign w_wr_ok = i_we && ({1'b0, i_addr} < (AW+1)'(TAPS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        r_coef[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_coef[i_addr] <= i_din;
    end
  end

  assign o_rd_data = r_coef[i_rd_addr];

endmodule

// File: rtl/fir_mac_engine.sv
// FIR core fed from a registered-output FIFO: one sample per pass, one shared
// multiplier stepping over TAPS cycles, result held on a valid/ready port.
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter int TAPS   = FIR_TAPS_DEF,
  parameter int DWIDTH = FIR_DWIDTH_DEF,
  parameter int CWIDTH = FIR_CWIDTH_DEF,
  parameter int OWIDTH = fir_owidth(DWIDTH, CWIDTH, TAPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  input  logic [DWIDTH-1:0]       fifo_dout,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [CWIDTH-1:0]       coef_din,
  output logic [OWIDTH-1:0]       y_data,
  output logic                    y_valid,
  input  logic                    y_ready,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  // Output handshake: y_data is transferred on a rising edge where y_valid and
  // y_ready are both high; y_valid and y_data hold until that edge.
  localparam int AW = $clog2(TAPS);
  localparam int PW = DWIDTH + CWIDTH;

  logic [1:0]               r_state;
  logic signed [DWIDTH-1:0] r_x [TAPS];
  logic signed [OWIDTH-1:0] r_acc;
  logic signed [OWIDTH-1:0] r_y_data;
  logic [AW-1:0]            r_k;

  logic [CWIDTH-1:0]        w_coef;
  logic signed [PW-1:0]     w_prod;
  logic signed [OWIDTH-1:0] w_prod_ext;
  logic signed [OWIDTH-1:0] w_acc_next;
  logic                     w_last;
  logic                     w_coef_we;

  assign busy       = (r_state != FIR_IDLE);
  assign y_valid    = (r_state == FIR_OUT);
  assign y_data     = r_y_data;
  assign dbg_state  = r_state;
  assign fifo_rd_en = !rst && (r_state == FIR_IDLE) && !fifo_empty;
  assign w_coef_we  = coef_we && !busy;

  fir_coef_bank #(
    .TAPS   (TAPS),
    .CWIDTH (CWIDTH),
    .AW     (AW)
  ) u_coef_bank (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_coef_we),
    .i_addr    (coef_addr),
    .i_din     (coef_din),
    .i_rd_addr (r_k),
    .o_rd_data (w_coef)
  );

  assign w_prod     = r_x[r_k] * $signed(w_coef);
  assign w_prod_ext = {{(OWIDTH-PW){w_prod[PW-1]}}, w_prod};
  assign w_acc_next = r_acc + w_prod_ext;
  assign w_last     = (r_k == AW'(TAPS-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= FIR_IDLE;
      r_acc    <= '0;
      r_y_data <= '0;
      r_k      <= '0;
      for (int i = 0; i < TAPS; i++) begin
        r_x[i] <= '0;
      end
    end else begin
      case (r_state)
        FIR_IDLE: begin
          if (fifo_rd_en) begin
            r_state <= FIR_LOAD;
          end
        end
        FIR_LOAD: begin
          // FIFO data is registered, so it is valid in the cycle after the read.
          r_x[0] <= $signed(fifo_dout);
          for (int i = 1; i < TAPS; i++) begin
            r_x[i] <= r_x[i-1];
          end
          r_acc   <= '0;
          r_k     <= '0;
          r_state <= FIR_MAC;
        end
        FIR_MAC: begin
          r_acc <= w_acc_next;
          r_k   <= r_k + AW'(1);
          if (w_last) begin
            r_y_data <= w_acc_next;
            r_state  <= FIR_OUT;
          end
        end
        FIR_OUT: begin
          if (y_ready) begin
            r_state <= FIR_IDLE;
          end
        end
        default: r_state <= FIR_IDLE;
      endcase
    end
  end

endmodule
